// File: rtl/lsu_mem_master_if.sv
// Bundles the pipeline request/response handshake and the data-memory port of the MEM-stage load/store unit.
// The master modport is the unit's view; the slave modport is the pipeline-plus-memory side.
interface lsu_mem_master_if #(
   parameter int WORD = 32
);
   logic            req_valid;
   logic            req_ready;
   logic [2:0]      req_op;
   logic [WORD-1:0] req_addr;
   logic [WORD-1:0] req_wdata;
   logic            resp_valid;
   logic            resp_ready;
   logic [WORD-1:0] resp_data;
   logic            resp_err;
   logic [WORD-1:0] mem_addr;
   logic [WORD-1:0] mem_wdata;
   logic            mem_read;
   logic            mem_write;
   logic [WORD-1:0] mem_rdata;

   modport master (
      input  req_valid, req_op, req_addr, req_wdata, resp_ready, mem_rdata,
      output req_ready, resp_valid, resp_data, resp_err, mem_addr, mem_wdata, mem_read, mem_write
   );

   modport slave (
      output req_valid, req_op, req_addr, req_wdata, resp_ready, mem_rdata,
      input  req_ready, resp_valid, resp_data, resp_err, mem_addr, mem_wdata, mem_read, mem_write
   );
endinterface

// File: rtl/lsu_mem_master.sv
// MEM-stage load/store unit: one request at a time against a big-endian, word-wide data memory,
// with lane extraction/extension on loads and read-modify-write for byte/halfword stores.
module lsu_mem_master #(
   parameter int WORD      = 32,
   parameter int MEM_BYTES = 1000
) (
   input logic              clk,
   input logic              reset,
   lsu_mem_master_if.master bus
);
   typedef enum logic [2:0] {S_IDLE, S_READ, S_RMW_RD, S_WRITE, S_RESP} state_e;
   typedef enum logic [2:0] {
      OP_LW = 3'd0, OP_LH = 3'd1, OP_LHU = 3'd2, OP_LB = 3'd3,
      OP_LBU = 3'd4, OP_SW = 3'd5, OP_SH = 3'd6, OP_SB = 3'd7
   } op_e;

   localparam logic [WORD:0] LAST_BYTE = (WORD+1)'(MEM_BYTES - 1);

   state_e          state_q, state_d;
   op_e             op_q, op_d;
   logic [1:0]      off_q, off_d;
   logic [15:0]     sdata_q, sdata_d;
   logic [WORD-1:0] resp_data_q, resp_data_d;
   logic            resp_err_q, resp_err_d;
   logic            mem_read_q, mem_read_d;
   logic            mem_write_q, mem_write_d;
   logic [WORD-1:0] mem_addr_q, mem_addr_d;
   logic [WORD-1:0] mem_wdata_q, mem_wdata_d;

   op_e             req_op;
   logic [WORD-1:0] aligned_addr;
   logic [WORD:0]   last_touched;
   logic            misaligned;
   logic            out_of_range;

   // Byte k of a big-endian word lives at bits [WORD-1-8k -: 8].
   function automatic logic [WORD-1:0] load_extract(op_e op, logic [1:0] off, logic [WORD-1:0] rdata);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = rdata[WORD-1 -: 8];
         2'd1:    b = rdata[WORD-9 -: 8];
         2'd2:    b = rdata[WORD-17 -: 8];
         default: b = rdata[7:0];
      endcase
      h = off[1] ? rdata[15:0] : rdata[WORD-1 -: 16];
      case (op)
         OP_LW:   return rdata;
         OP_LH:   return {{(WORD-16){h[15]}}, h};
         OP_LHU:  return {{(WORD-16){1'b0}}, h};
         OP_LB:   return {{(WORD-8){b[7]}}, b};
         OP_LBU:  return {{(WORD-8){1'b0}}, b};
         default: return '0;
      endcase
   endfunction

   function automatic logic [WORD-1:0] store_merge(op_e op, logic [1:0] off, logic [WORD-1:0] rdata,
                                                   logic [15:0] sdata);
      logic [WORD-1:0] w;
      w = rdata;
      if (op == OP_SH) begin
         if (off[1]) w[15:0] = sdata;
         else        w[WORD-1 -: 16] = sdata;
      end else begin
         case (off)
            2'd0:    w[WORD-1 -: 8]  = sdata[7:0];
            2'd1:    w[WORD-9 -: 8]  = sdata[7:0];
            2'd2:    w[WORD-17 -: 8] = sdata[7:0];
            default: w[7:0]          = sdata[7:0];
         endcase
      end
      return w;
   endfunction

   // Request decode: alignment and range are judged on the incoming request before anything is latched.
   always_comb begin
      req_op       = op_e'(bus.req_op);
      aligned_addr = {bus.req_addr[WORD-1:2], 2'b00};
      last_touched = {1'b0, aligned_addr} + (WORD+1)'(3);
      out_of_range = last_touched > LAST_BYTE;
      case (req_op)
         OP_LW, OP_SW:          misaligned = |bus.req_addr[1:0];
         OP_LH, OP_LHU, OP_SH:  misaligned = bus.req_addr[0];
         default:               misaligned = 1'b0;
      endcase
   end

   // Next-state logic; memory strobes are computed for the state being entered so they come straight from flops.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      off_d       = off_q;
      sdata_d     = sdata_q;
      resp_data_d = resp_data_q;
      resp_err_d  = resp_err_q;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               op_d        = req_op;
               off_d       = bus.req_addr[1:0];
               sdata_d     = bus.req_wdata[15:0];
               resp_data_d = '0;
               resp_err_d  = 1'b0;
               if (misaligned || out_of_range) begin
                  resp_err_d = 1'b1;
                  state_d    = S_RESP;
               end else begin
                  mem_addr_d = aligned_addr;
                  case (req_op)
                     OP_SW: begin
                        mem_write_d = 1'b1;
                        mem_wdata_d = bus.req_wdata;
                        state_d     = S_WRITE;
                     end
                     OP_SH, OP_SB: begin
                        mem_read_d = 1'b1;
                        state_d    = S_RMW_RD;
                     end
                     default: begin
                        mem_read_d = 1'b1;
                        state_d    = S_READ;
                     end
                  endcase
               end
            end
         end
         S_READ: begin
            resp_data_d = load_extract(op_q, off_q, bus.mem_rdata);
            state_d     = S_RESP;
         end
         S_RMW_RD: begin
            mem_write_d = 1'b1;
            mem_wdata_d = store_merge(op_q, off_q, bus.mem_rdata, sdata_q);
            state_d     = S_WRITE;
         end
         S_WRITE: state_d = S_RESP;
         S_RESP:  if (bus.resp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         op_q        <= OP_LW;
         off_q       <= 2'd0;
         sdata_q     <= '0;
         resp_data_q <= '0;
         resp_err_q  <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         off_q       <= off_d;
         sdata_q     <= sdata_d;
         resp_data_q <= resp_data_d;
         resp_err_q  <= resp_err_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign bus.req_ready  = (state_q == S_IDLE);
   assign bus.resp_valid = (state_q == S_RESP);
   assign bus.resp_data  = resp_data_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.mem_read   = mem_read_q;
   assign bus.mem_write  = mem_write_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
endmodule
